attn_score_mac: RTL and testbench

//  Datapath responder to the attention FSM controller's load_en / compute_en strobes.
//  - On load_en: captures one Q row vector and one K row vector.
//  - On compute_en: accumulates their dot product one element per cycle, then scales it
//    by an arithmetic right shift (1/sqrt(dk) approximation) and saturates it.
//  - Emits one raw attention score with a single-cycle valid pulse.

---
 rtl/attn_score_mac_if.sv | 28 ++
 rtl/attn_score_mac.sv | 133 +++++++++++++
 tb/tb_attn_score_mac.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/attn_score_mac_if.sv
// Strobe/vector bus between the attention controller and the score MAC.
// The controller drives master; the MAC datapath sits on slave.
interface attn_score_mac_if #(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int OUT_W = 16
);
  logic                    load_en;
  logic                    compute_en;
  logic [N*DW-1:0]         q_vec;
  logic [N*DW-1:0]         k_vec;
  logic signed [OUT_W-1:0] score;
  logic                    score_valid;
  logic                    busy;
  logic                    loaded;
  logic                    err;
  logic [1:0]              state_out;

  modport master (
    output load_en, compute_en, q_vec, k_vec,
    input  score, score_valid, busy, loaded, err, state_out
  );

  modport slave (
    input  load_en, compute_en, q_vec, k_vec,
    output score, score_valid, busy, loaded, err, state_out
  );
endinterface

// File: rtl/attn_score_mac.sv
// Q.K dot-product MAC: one element per cycle, then arithmetic
// right-shift scaling and saturation to a signed OUT_W score.
module attn_score_mac #(
  parameter int N     = 8,
  parameter int DW    = 8,
  parameter int SHIFT = 3,
  parameter int OUT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  attn_score_mac_if.slave bus
);
  localparam int ACC_W = 2*DW + $clog2(N);
  localparam int IW    = $clog2(N);

  localparam logic signed [OUT_W-1:0] OMAX =
    {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OMIN =
    {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] AMAX = ACC_W'(OMAX);
  localparam logic signed [ACC_W-1:0] AMIN = ACC_W'(OMIN);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MAC  = 2'b01,
    DONE = 2'b10,
    ILL  = 2'b11
  } state_e;

  state_e                  r_state, w_state;
  logic [IW-1:0]           r_idx, w_idx;
  logic signed [ACC_W-1:0] r_acc, w_acc;
  logic signed [DW-1:0]    r_q [N];
  logic signed [DW-1:0]    r_k [N];
  logic signed [DW-1:0]    w_q [N];
  logic signed [DW-1:0]    w_k [N];
  logic signed [OUT_W-1:0] r_score, w_score;
  logic                    r_valid, w_valid;
  logic                    r_loaded, w_loaded;
  logic                    r_err, w_err;

  logic signed [ACC_W-1:0] w_qe, w_ke, w_prod;
  logic signed [ACC_W-1:0] w_sh;
  logic signed [OUT_W-1:0] w_sat;

  // Operands widened first so the product keeps full precision
  assign w_qe   = ACC_W'(r_q[r_idx]);
  assign w_ke   = ACC_W'(r_k[r_idx]);
  assign w_prod = w_qe * w_ke;
  assign w_sh   = r_acc >>> SHIFT;
  assign w_sat  = (w_sh > AMAX) ? OMAX :
                  (w_sh < AMIN) ? OMIN :
                  w_sh[OUT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_acc    <= '0;
      r_q      <= '{default: '0};
      r_k      <= '{default: '0};
      r_score  <= '0;
      r_valid  <= 1'b0;
      r_loaded <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_idx    <= w_idx;
      r_acc    <= w_acc;
      r_q      <= w_q;
      r_k      <= w_k;
      r_score  <= w_score;
      r_valid  <= w_valid;
      r_loaded <= w_loaded;
      r_err    <= w_err;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_idx    = r_idx;
    w_acc    = r_acc;
    w_q      = r_q;
    w_k      = r_k;
    w_score  = r_score;
    w_valid  = 1'b0;
    w_loaded = r_loaded;
    w_err    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.load_en) begin
          for (int i = 0; i < N; i++) begin
            w_q[i] = bus.q_vec[i*DW +: DW];
            w_k[i] = bus.k_vec[i*DW +: DW];
          end
          w_loaded = 1'b1;
          w_err    = bus.compute_en;
        end else if (bus.compute_en) begin
          if (r_loaded) begin
            w_state = MAC;
            w_idx   = '0;
            w_acc   = '0;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      MAC: begin
        w_acc = r_acc + w_prod;
        w_idx = r_idx + IW'(1);
        if (r_idx == IW'(N-1)) begin
          w_state = DONE;
          w_idx   = '0;
        end
        w_err = bus.load_en | bus.compute_en;
      end
      DONE: begin
        w_score = w_sat;
        w_valid = 1'b1;
        w_state = IDLE;
        w_err   = bus.load_en | bus.compute_en;
      end
      default: w_state = IDLE;
    endcase
  end

  assign bus.score       = r_score;
  assign bus.score_valid = r_valid;
  assign bus.busy        = (r_state != IDLE);
  assign bus.loaded      = r_loaded;
  assign bus.err         = r_err;
  assign bus.state_out   = r_state;
endmodule

// File: tb/tb_attn_score_mac.sv
// Random and directed checks of attn_score_mac against a dot-product
// model; instance a uses SHIFT=3, instance b uses SHIFT=0.
module tb_attn_score_mac;
  localparam int N     = 8;
  localparam int DW    = 8;
  localparam int OUT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  attn_score_mac_if #(.N(N), .DW(DW), .OUT_W(OUT_W)) a_if ();
  attn_score_mac_if #(.N(N), .DW(DW), .OUT_W(OUT_W)) b_if ();

  attn_score_mac #(.N(N), .DW(DW), .SHIFT(3), .OUT_W(OUT_W)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );
  attn_score_mac #(.N(N), .DW(DW), .SHIFT(0), .OUT_W(OUT_W)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int mq [N];
  int mk [N];
  int vq [N];
  int vk [N];
  int wq [N];

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack(input int v [N]);
    logic [N*DW-1:0] p;
    int t;
    p = '0;
    for (int i = 0; i < N; i++) begin
      t = v[i];
      p[i*DW +: DW] = t[DW-1:0];
    end
    return p;
  endfunction

  function automatic int ref_score(input int sh);
    int d;
    int lim;
    d = 0;
    for (int i = 0; i < N; i++) d += mq[i] * mk[i];
    d = d >>> sh;
    lim = 1 << (OUT_W-1);
    if (d > lim - 1) d = lim - 1;
    if (d < -lim) d = -lim;
    return d;
  endfunction

  task automatic set_vec(input logic [N*DW-1:0] q,
                         input logic [N*DW-1:0] k);
    a_if.q_vec = q; a_if.k_vec = k;
    b_if.q_vec = q; b_if.k_vec = k;
  endtask

  task automatic set_strb(input logic ld, input logic cp);
    a_if.load_en = ld; a_if.compute_en = cp;
    b_if.load_en = ld; b_if.compute_en = cp;
  endtask

  task automatic do_load(input int q [N], input int k [N]);
    set_vec(pack(q), pack(k));
    set_strb(1'b1, 1'b0);
    @(posedge clk); #1;
    set_strb(1'b0, 1'b0);
    mq = q;
    mk = k;
  endtask

  task automatic start_compute();
    set_strb(1'b0, 1'b1);
    @(posedge clk); #1;
    set_strb(1'b0, 1'b0);
  endtask

  // Returns at the negedge showing score_valid
  task automatic wait_result(input string tag, input bit inj);
    int lat;
    int nb;
    lat = -1;
    nb  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) chk({tag, "_st_mac"}, a_if.state_out, 1);
      if (c == N) chk({tag, "_st_done"}, a_if.state_out, 2);
      if (inj && c == 3) begin
        chk({tag, "_busy_err"}, a_if.err, 1);
        set_strb(1'b0, 1'b0);
      end
      if (a_if.score_valid) begin
        lat = c;
        break;
      end
      if (a_if.busy) nb++;
      if (inj && c == 2) begin
        set_vec(pack(wq), pack(wq));
        set_strb(1'b1, 1'b0);
      end
    end
    chk({tag, "_latency"}, lat, N+1);
    chk({tag, "_busy_cyc"}, nb, N+1);
    chk({tag, "_busy_end"}, a_if.busy, 0);
    chk({tag, "_b_valid"}, b_if.score_valid, 1);
    chk({tag, "_a_score"}, a_if.score, ref_score(3));
    chk({tag, "_b_score"}, b_if.score, ref_score(0));
  endtask

  task automatic rand_vec(output int v [N]);
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i] = -128;
        1:       v[i] = 127;
        default: v[i] = int'($urandom_range(0, 255)) - 128;
      endcase
    end
  endtask

  initial begin
    int nv;
    rst_n = 1'b0;
    set_strb(1'b0, 1'b0);
    set_vec('0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_score", a_if.score, 0);
    chk("rst_valid", a_if.score_valid, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_loaded", a_if.loaded, 0);
    chk("rst_err", a_if.err, 0);
    chk("rst_state", a_if.state_out, 0);
    rst_n = 1'b1;

    // compute before any load
    start_compute();
    @(negedge clk);
    chk("noload_err", a_if.err, 1);
    chk("noload_busy", a_if.busy, 0);
    @(negedge clk);
    chk("noload_err_clr", a_if.err, 0);

    vq = '{default: 1};
    vk = '{default: 2};
    do_load(vq, vk);
    chk("basic_loaded", a_if.loaded, 1);
    start_compute();
    wait_result("basic", 1'b0);
    chk("basic_exact", a_if.score, 2);

    vq = '{1, -2, 3, -4, 5, -6, 7, -8};
    vk = '{default: 8};
    @(negedge clk);
    do_load(vq, vk);
    start_compute();
    wait_result("mixed", 1'b0);
    chk("mixed_exact", a_if.score, -4);
    @(negedge clk);
    chk("mixed_pulse", a_if.score_valid, 0);

    vq = '{default: -128};
    vk = '{default: -128};
    do_load(vq, vk);
    start_compute();
    wait_result("sat_pos", 1'b0);
    chk("sat_pos_exact", b_if.score, 32767);
    vk = '{default: 127};
    @(negedge clk);
    do_load(vq, vk);
    start_compute();
    wait_result("sat_neg", 1'b0);
    chk("sat_neg_exact", b_if.score, -32768);

    // load and compute on the same edge
    rand_vec(vq);
    rand_vec(vk);
    @(negedge clk);
    set_vec(pack(vq), pack(vk));
    set_strb(1'b1, 1'b1);
    @(posedge clk); #1;
    set_strb(1'b0, 1'b0);
    mq = vq;
    mk = vk;
    @(negedge clk);
    chk("both_err", a_if.err, 1);
    chk("both_busy", a_if.busy, 0);
    chk("both_loaded", a_if.loaded, 1);
    start_compute();
    wait_result("both", 1'b0);

    // load during MAC must not disturb the captured vectors
    rand_vec(wq);
    @(negedge clk);
    start_compute();
    wait_result("ldmac", 1'b1);
    @(negedge clk);
    start_compute();
    wait_result("ldmac2", 1'b0);

    // back-to-back: accept in the valid cycle
    start_compute();
    wait_result("b2b", 1'b0);

    for (int t = 0; t < 8; t++) begin
      rand_vec(vq);
      rand_vec(vk);
      @(negedge clk);
      do_load(vq, vk);
      start_compute();
      wait_result($sformatf("rnd%0d", t), 1'b0);
    end

    // reset in the middle of MAC
    @(negedge clk);
    start_compute();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_score", a_if.score, 0);
    chk("mrst_valid", a_if.score_valid, 0);
    chk("mrst_busy", a_if.busy, 0);
    chk("mrst_loaded", a_if.loaded, 0);
    chk("mrst_state", a_if.state_out, 0);
    chk("mrst_b_score", b_if.score, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (15) begin
      @(negedge clk);
      if (a_if.score_valid || b_if.score_valid) nv++;
    end
    chk("mrst_no_valid", nv, 0);
    chk("mrst_idle", a_if.state_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
